// File: rtl/alu_shift_seq.sv
// Multi-cycle SLL/SRL/ROR/SRA shift unit. It moves at most STEP bits per clock
// and uses valid/ready handshakes for both the operands and the result.
module alu_shift_seq #(
  parameter int XLEN = 32,
  parameter int STEP = 4,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            busy
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  // STEP may equal XLEN, which does not fit in SHW bits. The compare therefore
  // uses one extra bit. The truncated STEP_K is only selected when rem > STEP,
  // so STEP < XLEN whenever it is used.
  localparam logic [SHW:0]   STEP_X = (SHW+1)'(STEP);
  localparam logic [SHW-1:0] STEP_K = SHW'(STEP);

  state_e          r_state, w_state_next;
  op_e             r_op;
  logic [XLEN-1:0] r_acc, r_rd, w_acc_step;
  logic [SHW-1:0]  r_rem, w_k, w_rem_step;
  logic            w_accept;
  logic            w_unused;

  // The shift amount is taken modulo XLEN. The upper rs2 bits are ignored on purpose.
  assign w_unused   = ^rs2[XLEN-1:SHW];
  assign w_accept   = in_valid && in_ready;
  assign w_k        = ({1'b0, r_rem} > STEP_X) ? STEP_K : r_rem;
  assign w_rem_step = r_rem - w_k;

  always_comb begin
    w_acc_step = r_acc;
    case (r_op)
      OP_SLL: w_acc_step = r_acc << w_k;
      OP_SRL: w_acc_step = r_acc >> w_k;
      // The left amount is XLEN-k, computed modulo XLEN. k is never 0 while shifting.
      OP_ROR: w_acc_step = (r_acc >> w_k) | (r_acc << (SHW'(0) - w_k));
      OP_SRA: w_acc_step = $unsigned($signed(r_acc) >>> w_k);
      default: w_acc_step = r_acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: every output of this block is given a default first; otherwise latches are inferred.
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = (rs2[SHW-1:0] == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_rem_step == '0) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // r_rd loads only on entry to DONE, so the result stays stable under backpressure and after the handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_rem <= '0;
      r_op  <= OP_SLL;
      r_rd  <= '0;
    end else if (w_accept) begin
      r_acc <= rs1;
      r_rem <= rs2[SHW-1:0];
      r_op  <= op_e'(op);
      if (rs2[SHW-1:0] == '0) r_rd <= rs1;
    end else if (r_state == S_SHIFT) begin
      r_acc <= w_acc_step;
      r_rem <= w_rem_step;
      if (w_rem_step == '0) r_rd <= w_acc_step;
    end
  end

  assign rd = r_rd;

endmodule
